step_gen: RTL and testbench
===========================

# step_gen

Pipeline step generator for the lab board. It takes the divided slow clock (`clk_dv`) and a raw single-step pushbutton into the fast `clk` domain, and issues one-cycle `step_en` pulses that advance the pipeline. Stepping is either free-running on each `clk_dv` rising edge or manual on each debounced button press. A `halt` request from the pipeline freezes stepping. The pipeline registers stay on `clk` and use `step_en` as a clock enable, so no logic is clocked by a derived clock.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synced-button cycles required before the debounced level changes; range 1..65535.
- `clk`  in  1  fast system clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clk_dv`  in  1  divided slow clock; treated as asynchronous and synchronized internally.
- `run`  in  1  level; 1 = free-run on `clk_dv` edges, 0 = manual step.
- `step_btn`  in  1  raw pushbutton, active-high, bouncy, asynchronous.
- `halt`  in  1  synchronous level from the pipeline; 1 = stop stepping.
- `step_en`  out  1  registered, one-cycle pipeline advance pulse.
- `halted`  out  1  registered; 1 while in HALT.
- `cycle_cnt`  out  16  registered count of issued `step_en` pulses.

## Operation
- **Reset (`rst`=0):**
  - `step_en`=0, `halted`=0, `cycle_cnt`=0, state STOP.
  - Sync flops, debounced level, debounce counter and the `primed` flag all clear to 0.
- **`clk_dv` path:**
  - 2-flop synchronizer, then a third flop for edge detect.
  - `tick` = `primed` & s2 & ~s3.
  - `primed` sets on the 3rd clk edge after reset release and stays set. A `clk_dv` that is already high at reset release therefore produces no tick.
- **Button path:**
  - 2-flop synchronizer produces `b_sync`.
  - A 16-bit counter increments while `b_sync` != `btn_db` and clears to 0 when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 with a mismatch, `btn_db` <= `b_sync` and the counter clears.
  - `press` = rising edge of `btn_db`, one cycle.
- **FSM (priority top-down each cycle):**
  - Any state, `halt`=1 → HALT. No `step_en` is issued that cycle, even if `tick`/`press` coincide.
  - STOP: if `run`=1 → RUN with no pulse this cycle. Otherwise `press` → `step_en` next cycle.
  - RUN: `run`=0 → STOP (a coincident `tick` is dropped). Otherwise `tick` → `step_en` next cycle. `press` is ignored.
  - HALT: `halt`=0 and `press` → STOP, no pulse. `tick` and `run` are ignored. `halted`=1 in HALT, 0 otherwise.
- **`cycle_cnt`:** increments on the same clock edge that sets `step_en`=1, so the value seen during the pulse cycle includes it. Wraps 0xFFFF → 0x0000 silently.
- **Reset mid-operation:** an in-flight pulse is cancelled immediately (asynchronous) and the counter clears.

## Timing
- `clk_dv` rising before clk edge E0 (setup met), in RUN:
  - s1 at E0, s2 at E1, `tick` during the cycle after E1.
  - `step_en`=1 from E2 to E3.
  - Latency is 3 edges, ±1 for metastability resolution.
- Button: `b_sync` follows `step_btn` by 2 edges. `btn_db` rises `DEBOUNCE_CYCLES` edges after the first mismatching `b_sync` cycle. `step_en` is high 1 edge after `btn_db` rises.
- A bounce shorter than `DEBOUNCE_CYCLES` synced cycles leaves `btn_db` unchanged.
- `step_en` is never high for 2 consecutive cycles. Minimum `clk_dv` period is 6 clk cycles. Holding the button high produces exactly one pulse.
- `run`, `halt` and `halted` act with 1-edge latency; no combinational path from inputs to outputs.

## Test plan
- **Reset and prime:** `clk_dv`=1 held through reset release, `run`=1 → no `step_en` in the first 10 cycles; `cycle_cnt`=0; `halted`=0.
- **Free run:** `clk_dv` divided by 200 (high 100 / low 100), `run`=1, 2000 cycles → 10 pulses, each 1 cycle wide and 3 edges after the `clk_dv` rise; `cycle_cnt`=10.
- **Debounce** (`DEBOUNCE_CYCLES`=4, `run`=0):
  - Glitches of 1, 2 and 3 cycles → no pulse.
  - Clean 20-cycle press → exactly 1 pulse, 2+4+1 edges after `step_btn` rises.
- **Halt priority:** in RUN, assert `halt` in the same cycle as `tick` → no pulse; `halted`=1 next edge; further `clk_dv` edges produce no pulse.
- **Halt release:** while halted, press the button with `halt`=1 → still HALT. Drop `halt`, then press → STOP with no pulse. Next press → 1 pulse, `cycle_cnt`+1.
- **Wrap and async reset:** preload the count to 0xFFFE with 2 steps → 0xFFFF then 0x0000. Pulse `rst` low mid-pulse → `step_en` drops to 0 immediately and state returns to STOP.

Source files
------------

// File: rtl/step_gen.sv
// Pipeline step generator: turns clk_dv edges (free-run) or debounced button
// presses (manual) into single-cycle step_en clock-enable pulses on clk.
module step_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_dv,
  input  logic        run,
  input  logic        step_btn,
  input  logic        halt,
  output logic        step_en,
  output logic        halted,
  output logic [15:0] cycle_cnt
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // clk_dv synchronizer, edge-detect flop and start-up priming
  logic       r_dv_s1;
  logic       r_dv_s2;
  logic       r_dv_s3;
  logic [1:0] r_prime_cnt;
  logic       r_primed;
  logic       w_tick;

  // priming keeps a clk_dv that is already high at reset release from ticking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dv_s1     <= 1'b0;
      r_dv_s2     <= 1'b0;
      r_dv_s3     <= 1'b0;
      r_prime_cnt <= 2'd0;
      r_primed    <= 1'b0;
    end else begin
      r_dv_s1 <= clk_dv;
      r_dv_s2 <= r_dv_s1;
      r_dv_s3 <= r_dv_s2;
      if (!r_primed) begin
        r_prime_cnt <= r_prime_cnt + 2'd1;
        if (r_prime_cnt == 2'd2) begin
          r_primed <= 1'b1;
        end
      end
    end
  end

  assign w_tick = r_primed & r_dv_s2 & ~r_dv_s3;

  // button synchronizer and debouncer
  logic        r_btn_s1;
  logic        r_btn_sync;
  logic [15:0] r_db_cnt;
  logic        r_btn_db;
  logic        r_btn_db_d;
  logic        w_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_s1   <= 1'b0;
      r_btn_sync <= 1'b0;
      r_db_cnt   <= 16'd0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
    end else begin
      r_btn_s1   <= step_btn;
      r_btn_sync <= r_btn_s1;
      r_btn_db_d <= r_btn_db;
      if (r_btn_sync != r_btn_db) begin
        // level must stay different for DEBOUNCE_CYCLES cycles in a row
        if (r_db_cnt == DB_LAST) begin
          r_btn_db <= r_btn_sync;
          r_db_cnt <= 16'd0;
        end else begin
          r_db_cnt <= r_db_cnt + 16'd1;
        end
      end else begin
        r_db_cnt <= 16'd0;
      end
    end
  end

  assign w_press = r_btn_db & ~r_btn_db_d;

  // stepping FSM with registered outputs
  state_t      r_state;
  logic        r_step_en;
  logic        r_halted;
  logic [15:0] r_cycle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_STOP;
      r_step_en   <= 1'b0;
      r_halted    <= 1'b0;
      r_cycle_cnt <= 16'd0;
    end else begin
      r_step_en <= 1'b0;
      if (halt) begin
        // halt wins over any coincident tick or press
        r_state  <= ST_HALT;
        r_halted <= 1'b1;
      end else begin
        case (r_state)
          ST_STOP: begin
            if (run) begin
              r_state <= ST_RUN;
            end else if (w_press) begin
              r_step_en   <= 1'b1;
              r_cycle_cnt <= r_cycle_cnt + 16'd1;
            end
          end
          ST_RUN: begin
            if (!run) begin
              r_state <= ST_STOP;
            end else if (w_tick) begin
              r_step_en   <= 1'b1;
              r_cycle_cnt <= r_cycle_cnt + 16'd1;
            end
          end
          ST_HALT: begin
            if (w_press) begin
              r_state  <= ST_STOP;
              r_halted <= 1'b0;
            end
          end
          default: begin
            r_state  <= ST_STOP;
            r_halted <= 1'b0;
          end
        endcase
      end
    end
  end

  assign step_en   = r_step_en;
  assign halted    = r_halted;
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_step_gen.sv
// Directed bench for step_gen: expected pulses (cycle, count) are queued when
// stimulus is driven and matched by a negedge monitor when step_en fires.
module tb_step_gen;

  logic        clk;
  logic        rst;
  logic        clk_dv;
  logic        run;
  logic        step_btn;
  logic        halt;
  logic        step_en;
  logic        halted;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_cnt = 16'd0;

  int          exp_cyc_q[$];
  logic [15:0] exp_cnt_q[$];

  step_gen #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_dv    (clk_dv),
    .run       (run),
    .step_btn  (step_btn),
    .halt      (halt),
    .step_en   (step_en),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue one expected pulse, 'lat' edges after the current negedge drive.
  task automatic expect_pulse(input int lat);
    exp_cnt = exp_cnt + 16'd1;
    exp_cyc_q.push_back(cyc + lat);
    exp_cnt_q.push_back(exp_cnt);
  endtask

  task automatic press(input int hold);
    step_btn = 1'b1;
    wait_cyc(hold);
    step_btn = 1'b0;
  endtask

  // Scoreboard side: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && step_en !== 1'b0) begin
      check("pulse_expected", 32'(exp_cyc_q.size() > 0), 32'd1);
      if (exp_cyc_q.size() > 0) begin
        int          ec;
        logic [15:0] en;
        ec = exp_cyc_q.pop_front();
        en = exp_cnt_q.pop_front();
        $display("pulse cycle=%0d cnt=%04h (expected cycle=%0d cnt=%04h)", cyc, cycle_cnt, ec, en);
        check("pulse_cycle", 32'(cyc), 32'(ec));
        check("pulse_cnt", {16'd0, cycle_cnt}, {16'd0, en});
      end
    end
  end

  initial begin
    rst      = 1'b0;
    clk_dv   = 1'b1;
    run      = 1'b1;
    step_btn = 1'b0;
    halt     = 1'b0;

    // reset and prime: clk_dv already high at release must not tick
    wait_cyc(3);
    check("rst_step_en", {31'd0, step_en}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cnt", {16'd0, cycle_cnt}, 32'd0);
    rst = 1'b1;
    wait_cyc(10);
    check("prime_cnt", {16'd0, cycle_cnt}, 32'd0);
    check("prime_halted", {31'd0, halted}, 32'd0);

    // free run, clk_dv / 200
    clk_dv = 1'b0;
    wait_cyc(100);
    for (int i = 0; i < 10; i++) begin
      clk_dv = 1'b1;
      expect_pulse(3);
      wait_cyc(100);
      clk_dv = 1'b0;
      wait_cyc(100);
    end
    check("free_cnt", {16'd0, cycle_cnt}, 32'd10);
    check("free_drained", 32'(exp_cyc_q.size()), 32'd0);

    // debounce in manual mode
    run = 1'b0;
    wait_cyc(5);
    for (int g = 1; g <= 3; g++) begin
      press(g);
      wait_cyc(12);
    end
    check("glitch_cnt", {16'd0, cycle_cnt}, 32'd10);
    expect_pulse(7);
    press(20);
    wait_cyc(20);
    check("press_cnt", {16'd0, cycle_cnt}, 32'd11);
    check("press_drained", 32'(exp_cyc_q.size()), 32'd0);

    // halt coincident with tick
    run = 1'b1;
    wait_cyc(5);
    clk_dv = 1'b1;
    wait_cyc(2);
    halt = 1'b1;
    wait_cyc(1);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_step_en", {31'd0, step_en}, 32'd0);
    clk_dv = 1'b0;
    wait_cyc(10);
    clk_dv = 1'b1;
    wait_cyc(10);
    clk_dv = 1'b0;
    wait_cyc(10);
    check("halt_hold", {31'd0, halted}, 32'd1);
    check("halt_cnt", {16'd0, cycle_cnt}, 32'd11);

    // halt release
    press(10);
    wait_cyc(15);
    check("halt_press_still", {31'd0, halted}, 32'd1);
    halt = 1'b0;
    run  = 1'b0;
    wait_cyc(3);
    check("halt_drop_still", {31'd0, halted}, 32'd1);
    press(10);
    wait_cyc(15);
    check("release_halted", {31'd0, halted}, 32'd0);
    check("release_cnt", {16'd0, cycle_cnt}, 32'd11);
    expect_pulse(7);
    press(10);
    wait_cyc(15);
    check("step_after_halt", {16'd0, cycle_cnt}, 32'd12);
    check("halt_drained", 32'(exp_cyc_q.size()), 32'd0);

    // wrap
    force dut.r_cycle_cnt = 16'hFFFE;
    #1;
    release dut.r_cycle_cnt;
    exp_cnt = 16'hFFFE;
    wait_cyc(1);
    check("preload", {16'd0, cycle_cnt}, 32'h0000FFFE);
    expect_pulse(7);
    press(10);
    wait_cyc(15);
    check("wrap_ffff", {16'd0, cycle_cnt}, 32'h0000FFFF);
    expect_pulse(7);
    press(10);
    wait_cyc(15);
    check("wrap_zero", {16'd0, cycle_cnt}, 32'd0);

    // asynchronous reset in the middle of a pulse
    expect_pulse(7);
    step_btn = 1'b1;
    wait_cyc(7);
    #1;
    check("pre_rst_step_en", {31'd0, step_en}, 32'd1);
    rst      = 1'b0;
    step_btn = 1'b0;
    #1;
    check("async_step_en", {31'd0, step_en}, 32'd0);
    check("async_cnt", {16'd0, cycle_cnt}, 32'd0);
    check("async_halted", {31'd0, halted}, 32'd0);
    wait_cyc(2);
    rst = 1'b1;
    exp_cnt = 16'd0;
    wait_cyc(5);
    expect_pulse(7);
    press(10);
    wait_cyc(15);
    check("post_rst_cnt", {16'd0, cycle_cnt}, 32'd1);
    check("final_drained", 32'(exp_cyc_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
